gpo_pad_seq: RTL and testbench

//   Digital sequencer directly upstream of the EG1 1.8V GPO pad cell; drives DO/DS/SR/CO/OE/ODP/ODN.

---
 rtl/gpo_pad_seq_if.sv | 32 +++
 rtl/gpo_pad_seq.sv | 145 ++++++++++++++
 tb/tb_gpo_pad_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpo_pad_seq_if.sv
// Core/pad-side signal bundle for the GPO pad sequencer.
// master = core + bias generator side, slave = sequencer.
interface gpo_pad_seq_if;
  logic       data;
  logic       oe_req;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ds;
  logic       cfg_sr;
  logic       cfg_co;
  logic [1:0] cfg_mode;
  logic       vbias_ok;
  logic       busy;
  logic       err;
  logic       pad_do;
  logic [1:0] pad_ds;
  logic       pad_sr;
  logic       pad_co;
  logic       pad_oe;
  logic       pad_odp;
  logic       pad_odn;

  modport master (
    output data, oe_req, cfg_valid, cfg_ds, cfg_sr, cfg_co, cfg_mode, vbias_ok,
    input  cfg_ready, busy, err, pad_do, pad_ds, pad_sr, pad_co, pad_oe, pad_odp, pad_odn
  );

  modport slave (
    input  data, oe_req, cfg_valid, cfg_ds, cfg_sr, cfg_co, cfg_mode, vbias_ok,
    output cfg_ready, busy, err, pad_do, pad_ds, pad_sr, pad_co, pad_oe, pad_odp, pad_odn
  );
endinterface

// File: rtl/gpo_pad_seq.sv
// Glitch-free drive-config sequencer for the EG1 1.8V GPO pad: tristate, apply, settle, re-enable.
// Optional GPO_SEQ_DATA_SYNC_EN adds a 2-flop synchronizer ahead of the DO register.
module gpo_pad_seq #(
  parameter int unsigned TRI_CYC    = 2,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned BIAS_TO    = 64,
  parameter int unsigned CNT_W      = 8
) (
  input logic         clk,
  input logic         rst,
  gpo_pad_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    APPLY,
    BIASWAIT
  } state_t;

  localparam logic [CNT_W-1:0] TRI_LD    = CNT_W'(TRI_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] BIAS_LD   = CNT_W'(BIAS_TO - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sh_ds;
  logic [1:0]       sh_mode;
  logic             sh_sr;
  logic             sh_co;
  logic             bias_lost;

  assign bias_lost = (bus.pad_ds != 2'b00) && !bus.vbias_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACTIVE;
      cnt           <= '0;
      sh_ds         <= '0;
      sh_mode       <= '0;
      sh_sr         <= 1'b0;
      sh_co         <= 1'b0;
      bus.pad_oe    <= 1'b0;
      bus.pad_ds    <= '0;
      bus.pad_sr    <= 1'b0;
      bus.pad_co    <= 1'b0;
      bus.pad_odp   <= 1'b0;
      bus.pad_odn   <= 1'b0;
      bus.cfg_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      unique case (state)
        ACTIVE: begin
          // A config offer takes priority over a bias drop in the same cycle.
          if (bus.cfg_valid) begin
            sh_ds         <= bus.cfg_ds;
            sh_mode       <= bus.cfg_mode;
            sh_sr         <= bus.cfg_sr;
            sh_co         <= bus.cfg_co;
            cnt           <= TRI_LD;
            state         <= DRAIN;
            bus.pad_oe    <= 1'b0;
            bus.cfg_ready <= 1'b0;
            bus.busy      <= 1'b1;
          end else if (bias_lost) begin
            cnt           <= BIAS_LD;
            state         <= BIASWAIT;
            bus.pad_oe    <= 1'b0;
            bus.cfg_ready <= 1'b0;
            bus.busy      <= 1'b1;
          end else begin
            bus.pad_oe    <= bus.oe_req;
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            cnt         <= SETTLE_LD;
            state       <= APPLY;
            bus.pad_ds  <= sh_ds;
            bus.pad_sr  <= sh_sr;
            bus.pad_co  <= sh_co;
            bus.pad_odp <= (sh_mode == 2'b01);
            bus.pad_odn <= (sh_mode == 2'b10);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        APPLY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (bias_lost) begin
            cnt   <= BIAS_LD;
            state <= BIASWAIT;
          end else begin
            // Leaving settle straight into drive: OE follows the request on this same edge.
            state         <= ACTIVE;
            bus.pad_oe    <= bus.oe_req;
            bus.cfg_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end
        BIASWAIT: begin
          if (bus.vbias_ok) begin
            state         <= ACTIVE;
            bus.cfg_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end else if (cnt == '0) begin
            state         <= ACTIVE;
            bus.pad_ds    <= 2'b00;
            bus.err       <= 1'b1;
            bus.cfg_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ACTIVE;
      endcase
    end
  end

`ifdef GPO_SEQ_DATA_SYNC_EN
  logic [1:0] data_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_sync  <= '0;
      bus.pad_do <= 1'b0;
    end else begin
      data_sync  <= {data_sync[0], bus.data};
      bus.pad_do <= data_sync[1];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pad_do <= 1'b0;
    end else begin
      bus.pad_do <= bus.data;
    end
  end
`endif

endmodule

// File: tb/tb_gpo_pad_seq.sv
// Randomized scoreboard bench for gpo_pad_seq against a transaction-level timeline model.
module tb_gpo_pad_seq;
  localparam int unsigned TRI_CYC    = 2;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned BIAS_TO    = 64;
`ifdef GPO_SEQ_DATA_SYNC_EN
  localparam int unsigned DO_LAT = 3;
`else
  localparam int unsigned DO_LAT = 1;
`endif

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       err;
    logic       dout;
    logic [1:0] ds;
    logic       sr;
    logic       co;
    logic       oe;
    logic       odp;
    logic       odn;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gpo_pad_seq_if bus ();

  gpo_pad_seq #(
    .TRI_CYC   (TRI_CYC),
    .SETTLE_CYC(SETTLE_CYC),
    .BIAS_TO   (BIAS_TO),
    .CNT_W     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  obs_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: events are placed on an absolute edge timeline.
  int unsigned cyc     = 0;
  int unsigned acc_at  = 0;
  int unsigned wait_at = 0;
  bit          in_seq  = 0;
  bit          in_wait = 0;
  obs_t        m;
  logic [1:0]  sh_ds, sh_mode;
  logic        sh_sr, sh_co;
  bit          dq[$];

  task automatic model_step();
    int unsigned k;
    if (rst) begin
      m       = '0;
      m.ready = 1'b1;
      in_seq  = 0;
      in_wait = 0;
      dq.delete();
      for (int unsigned i = 1; i < DO_LAT; i++) dq.push_back(1'b0);
      return;
    end
    dq.push_back(bus.data);
    m.dout = dq.pop_front();
    if (in_seq) begin
      k = cyc - acc_at;
      m.oe = 1'b0;
      if (k == TRI_CYC) begin
        m.ds  = sh_ds;
        m.sr  = sh_sr;
        m.co  = sh_co;
        m.odp = (sh_mode == 2'b01);
        m.odn = (sh_mode == 2'b10);
      end
      if (k == TRI_CYC + SETTLE_CYC) begin
        in_seq = 0;
        if (m.ds != 2'b00 && !bus.vbias_ok) begin
          in_wait = 1;
          wait_at = cyc;
        end else begin
          m.oe = bus.oe_req;
        end
      end
    end else if (in_wait) begin
      k = cyc - wait_at;
      m.oe = 1'b0;
      if (bus.vbias_ok) begin
        in_wait = 0;
      end else if (k == BIAS_TO) begin
        m.ds    = 2'b00;
        m.err   = 1'b1;
        in_wait = 0;
      end
    end else begin
      if (bus.cfg_valid) begin
        sh_ds   = bus.cfg_ds;
        sh_mode = bus.cfg_mode;
        sh_sr   = bus.cfg_sr;
        sh_co   = bus.cfg_co;
        in_seq  = 1;
        acc_at  = cyc;
        m.oe    = 1'b0;
      end else if (m.ds != 2'b00 && !bus.vbias_ok) begin
        in_wait = 1;
        wait_at = cyc;
        m.oe    = 1'b0;
      end else begin
        m.oe = bus.oe_req;
      end
    end
    m.busy  = in_seq | in_wait;
    m.ready = !m.busy;
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      sb.push_back(m);
      cyc++;
      #1;
    end
  endtask

  task automatic set_cfg(input logic [1:0] ds, input logic [1:0] mode, input logic sr, input logic co);
    bus.cfg_ds   = ds;
    bus.cfg_mode = mode;
    bus.cfg_sr   = sr;
    bus.cfg_co   = co;
  endtask

  task automatic offer(input logic [1:0] ds, input logic [1:0] mode);
    set_cfg(ds, mode, 1'b1, 1'b0);
    bus.cfg_valid = 1'b1;
    step(1);
    bus.cfg_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = {bus.cfg_ready, bus.busy, bus.err, bus.pad_do, bus.pad_ds, bus.pad_sr,
           bus.pad_co, bus.pad_oe, bus.pad_odp, bus.pad_odn};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL outputs t=%0t got=%b required=%b (ready busy err do ds[1:0] sr co oe odp odn)",
                    $time, a, e);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    bit          vb_cur = 1;
    int unsigned vb_run = 0;
    bus.data      = 1'b0;
    bus.oe_req    = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.vbias_ok  = 1'b1;
    set_cfg(2'b00, 2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    step(3);
    rst         = 1'b0;
    bus.oe_req  = 1'b1;
    bus.data    = 1'b1;
    step(4);

    // Drive-strength change with bias present, then toggle data.
    offer(2'b10, 2'b01);
    step(12);
    for (int unsigned i = 0; i < 8; i++) begin
      bus.data = ~bus.data;
      step(1);
    end

    // Strong drive without bias: timeout fallback, with an ignored offer mid-wait.
    bus.vbias_ok = 1'b0;
    offer(2'b11, 2'b10);
    step(20);
    bus.cfg_valid = 1'b1;
    step(1);
    bus.cfg_valid = 1'b0;
    step(60);
    bus.vbias_ok = 1'b1;
    step(5);

    // Weak drive, then bias drop in ACTIVE and recovery 5 cycles later.
    offer(2'b01, 2'b11);
    step(10);
    bus.vbias_ok = 1'b0;
    step(5);
    bus.vbias_ok = 1'b1;
    step(6);

    // Reset during settle discards the pending config.
    offer(2'b11, 2'b01);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(8);

    // Back-to-back offers held high across the whole sequence.
    set_cfg(2'b10, 2'b10, 1'b0, 1'b1);
    bus.cfg_valid = 1'b1;
    step(9);
    set_cfg(2'b01, 2'b00, 1'b1, 1'b1);
    step(9);
    bus.cfg_valid = 1'b0;
    step(4);

    for (int unsigned i = 0; i < 2500; i++) begin
      if (vb_run == 0) begin
        vb_cur = ($urandom_range(0, 5) != 0);
        vb_run = vb_cur ? $urandom_range(5, 60) : $urandom_range(1, 90);
      end
      vb_run--;
      bus.vbias_ok  = vb_cur;
      rst           = ($urandom_range(0, 299) == 0);
      bus.data      = 1'($urandom);
      bus.oe_req    = ($urandom_range(0, 3) != 0);
      bus.cfg_valid = ($urandom_range(0, 5) == 0);
      set_cfg(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      step(1);
    end
    rst           = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.vbias_ok  = 1'b1;
    step(4);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got=%0d entries left required=0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
